mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width.
REQ-002 Parameter: DATA_W, 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter: STARVE_MAX, 4, consecutive instruction-fetch losses before fetch is forced to win.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_req  in  1  fetch request; i_addr  in  ADDR_W  fetch address.
REQ-007 i_gnt  out  1  fetch accepted; i_rvalid  out  1  fetch data valid; i_rdata  out  DATA_W  fetch data.
REQ-008 d_req  in  1  load/store request; d_we  in  1  write; d_be  in  DATA_W/8  byte enables; d_addr  in  ADDR_W; d_wdata  in  DATA_W.
REQ-009 d_gnt  out  1  data request accepted; d_rvalid  out  1  load data / store ack; d_rdata  out  DATA_W.
REQ-010 m_req, m_we  out  1; m_be  out  DATA_W/8; m_addr  out  ADDR_W; m_wdata  out  DATA_W: shared memory port, all registered.
REQ-011 m_gnt  in  1  memory accepts; m_rvalid  in  1  response valid; m_rdata  in  DATA_W.

Function
REQ-012 FSM states SHALL be IDLE, REQ, RSP; at most one transaction outstanding.
REQ-013 IDLE: if no request, stay IDLE; else arbitrate, latch owner and the winner's addr/we/be/wdata into m_*, set m_req=1, go to REQ next cycle.
REQ-014 Arbitration: data wins when both requests are active, unless starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-015 Fetch-only requests SHALL be latched with m_we=0, m_be=all ones, m_wdata=0.
REQ-016 starve_cnt SHALL increment (saturating at STARVE_MAX) on each arbitration where data wins while i_req=1; it SHALL clear to 0 when fetch wins.
REQ-017 REQ: m_req and m_* SHALL hold stable until m_gnt=1; on m_gnt, pulse the owner's gnt (i_gnt or d_gnt) combinationally in that cycle, drop m_req, go to RSP.
REQ-018 i_gnt and d_gnt SHALL never be asserted in the same cycle, and only in REQ with m_gnt=1.
REQ-019 RSP: on m_rvalid=1, assert the owner's rvalid combinationally that cycle, return to IDLE; the other rvalid stays 0.
REQ-020 i_rdata and d_rdata SHALL equal m_rdata continuously; consumers sample only with their rvalid.
REQ-021 m_rvalid in IDLE or REQ SHALL be ignored (no rvalid output, no state change).
REQ-022 Requesters hold req and payload stable until gnt; a request withdrawn before its gnt is a protocol violation, but the arbiter SHALL still complete the latched transaction.
REQ-023 Minimum latency: request seen in IDLE cycle 0, m_req cycle 1, gnt cycle 1 if m_gnt=1, rvalid cycle 2 at earliest, next arbitration cycle 3.
REQ-024 m_gnt and m_rvalid in the same cycle in REQ: gnt handled, m_rvalid ignored per REQ-021.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, starve_cnt 0, owner cleared, m_req/m_we/m_be/m_addr/m_wdata 0, i_gnt/d_gnt/i_rvalid/d_rvalid 0.
REQ-026 Reset asserted in REQ or RSP SHALL abandon the transaction; a late m_rvalid after reset release is ignored.
REQ-027 First arbitration SHALL occur on the first rising edge with rst_n high.

Verification
REQ-028 Fetch only, i_addr=0x100, m_gnt=1, m_rvalid one cycle later with m_rdata=0x00000013 -> m_req at cycle 1, i_gnt cycle 1, i_rvalid with i_rdata=0x13 cycle 2, d_* silent.
REQ-029 Store d_addr=0x2000, d_be=0x3, d_wdata=0xDEADBEEF, m_gnt delayed 3 cycles -> m_* stable for 3 cycles, d_gnt on 4th, d_rvalid on ack.
REQ-030 i_req and d_req held high continuously, memory always ready -> grant order D,D,D,D,I repeating (STARVE_MAX=4); starve_cnt returns to 0 after each I.
REQ-031 Spurious m_rvalid in IDLE and in REQ -> no i_rvalid/d_rvalid, FSM unchanged.
REQ-032 rst_n pulsed low in RSP, then m_rvalid after release -> all outputs 0 during reset, no rvalid forwarded, next request arbitrates normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one registered memory port between an instruction-fetch
// requester and a load/store requester, one transaction in flight at a time.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  // instruction-fetch port
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  // load/store port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // shared memory port
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  state_t            r_state,      w_state_nxt;
  owner_t            r_owner,      w_owner_nxt;
  logic [CNT_W-1:0]  r_starve_cnt, w_starve_nxt;
  logic              r_m_req,      w_m_req_nxt;
  logic              r_m_we,       w_m_we_nxt;
  logic [BE_W-1:0]   r_m_be,       w_m_be_nxt;
  logic [ADDR_W-1:0] r_m_addr,     w_m_addr_nxt;
  logic [DATA_W-1:0] r_m_wdata,    w_m_wdata_nxt;
  logic              w_fetch_wins;
  logic              w_starved;

  assign w_starved    = (r_starve_cnt == CNT_W'(STARVE_MAX));
  assign w_fetch_wins = i_req && (!d_req || w_starved);

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves a signal unassigned (which would infer a latch).
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_starve_nxt  = r_starve_cnt;
    w_m_req_nxt   = r_m_req;
    w_m_we_nxt    = r_m_we;
    w_m_be_nxt    = r_m_be;
    w_m_addr_nxt  = r_m_addr;
    w_m_wdata_nxt = r_m_wdata;
    i_gnt         = 1'b0;
    d_gnt         = 1'b0;
    i_rvalid      = 1'b0;
    d_rvalid      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (i_req || d_req) begin
          w_state_nxt = REQ;
          w_m_req_nxt = 1'b1;
          if (w_fetch_wins) begin
            w_owner_nxt   = OWN_I;
            w_m_we_nxt    = 1'b0;
            w_m_be_nxt    = '1;
            w_m_addr_nxt  = i_addr;
            w_m_wdata_nxt = '0;
            w_starve_nxt  = '0;
          end else begin
            w_owner_nxt   = OWN_D;
            w_m_we_nxt    = d_we;
            w_m_be_nxt    = d_be;
            w_m_addr_nxt  = d_addr;
            w_m_wdata_nxt = d_wdata;
            // fetch lost while asking: count toward forcing it through
            if (i_req && !w_starved) w_starve_nxt = r_starve_cnt + CNT_W'(1);
          end
        end
      end
      REQ: begin
        if (m_gnt) begin
          i_gnt       = (r_owner == OWN_I);
          d_gnt       = (r_owner == OWN_D);
          w_m_req_nxt = 1'b0;
          w_state_nxt = RSP;
        end
      end
      RSP: begin
        if (m_rvalid) begin
          i_rvalid    = (r_owner == OWN_I);
          d_rvalid    = (r_owner == OWN_D);
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= OWN_NONE;
      r_starve_cnt <= '0;
      r_m_req      <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_be       <= '0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_m_req      <= w_m_req_nxt;
      r_m_we       <= w_m_we_nxt;
      r_m_be       <= w_m_be_nxt;
      r_m_addr     <= w_m_addr_nxt;
      r_m_wdata    <= w_m_wdata_nxt;
    end
  end

  assign m_req   = r_m_req;
  assign m_we    = r_m_we;
  assign m_be    = r_m_be;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;

  // read data is broadcast; each requester qualifies it with its own rvalid
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic scored against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_gnt, i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [BE_W-1:0]   d_be = '0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req, m_we;
  logic [BE_W-1:0]   m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_gnt = 1'b0;
  logic              m_rvalid = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;
  int starve = 0;  // model: consecutive fetch losses

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  // One full transaction starting at the negedge of the IDLE cycle in which the
  // caller has already set up the requests. gd/rd = memory wait cycles.
  task automatic run_txn(input int gd, input int rd, input logic [DATA_W-1:0] rdata,
                         input string tag);
    bit                exp_i;
    logic              e_we;
    logic [BE_W-1:0]   e_be;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    exp_i = i_req && (!d_req || starve == STARVE_MAX);
    if (exp_i) begin
      e_we = 1'b0; e_be = '1; e_addr = i_addr; e_wdata = '0; starve = 0;
    end else begin
      e_we = d_we; e_be = d_be; e_addr = d_addr; e_wdata = d_wdata;
      if (i_req && starve < STARVE_MAX) starve++;
    end

    m_gnt = 1'b0; m_rvalid = 1'($urandom_range(0, 1)); #1;
    n_cmp++;
    if ({m_req, i_gnt, d_gnt, i_rvalid, d_rvalid} !== 5'b0) begin
      n_err++;
      $display("FAIL %s idle_outputs: got %b want 00000", tag,
               {m_req, i_gnt, d_gnt, i_rvalid, d_rvalid});
    end
    @(negedge clk);

    for (int k = 0; k <= gd; k++) begin
      m_gnt = (k == gd); m_rvalid = 1'($urandom_range(0, 1)); m_rdata = $urandom; #1;
      n_cmp++;
      if ({m_req, m_we, m_be, m_addr, m_wdata} !== {1'b1, e_we, e_be, e_addr, e_wdata}) begin
        n_err++;
        $display("FAIL %s mem_port cyc%0d: got req=%b we=%b be=%h addr=%h wdata=%h want 1 %b %h %h %h",
                 tag, k, m_req, m_we, m_be, m_addr, m_wdata, e_we, e_be, e_addr, e_wdata);
      end
      n_cmp++;
      if ({i_gnt, d_gnt, i_rvalid, d_rvalid} !== {(k == gd) && exp_i, (k == gd) && !exp_i, 2'b00}) begin
        n_err++;
        $display("FAIL %s gnt cyc%0d: got i_gnt=%b d_gnt=%b rv=%b%b want i_gnt=%b d_gnt=%b rv=00",
                 tag, k, i_gnt, d_gnt, i_rvalid, d_rvalid, (k == gd) && exp_i, (k == gd) && !exp_i);
      end
      @(negedge clk);
    end

    if (exp_i) i_req = 1'b0; else d_req = 1'b0;

    for (int k = 0; k <= rd; k++) begin
      m_gnt = 1'($urandom_range(0, 1)); m_rvalid = (k == rd);
      m_rdata = (k == rd) ? rdata : $urandom; #1;
      n_cmp++;
      if ({m_req, i_gnt, d_gnt, i_rvalid, d_rvalid} !==
          {3'b000, (k == rd) && exp_i, (k == rd) && !exp_i}) begin
        n_err++;
        $display("FAIL %s rsp cyc%0d: got req=%b gnt=%b%b rv=%b%b want rv=%b%b", tag, k,
                 m_req, i_gnt, d_gnt, i_rvalid, d_rvalid, (k == rd) && exp_i, (k == rd) && !exp_i);
      end
      if (k == rd) begin
        n_cmp++;
        if (i_rdata !== rdata || d_rdata !== rdata) begin
          n_err++;
          $display("FAIL %s rdata: got i=%h d=%h want %h", tag, i_rdata, d_rdata, rdata);
        end
      end
      @(negedge clk);
    end
    m_gnt = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h55; d_addr = 32'h66; d_be = '1;
    m_gnt = 1'b1; m_rvalid = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, m_be, m_addr, m_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b req=%b we=%b be=%h addr=%h wdata=%h want all 0",
               i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, m_be, m_addr, m_wdata);
    end
    i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    starve = 0;
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 32'h100; d_req = 1'b0;
    run_txn(0, 0, 32'h0000_0013, "fetch");
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    i_req = 1'b0;
    run_txn(3, 1, $urandom, "store");
  endtask

  task automatic test_starve();
    for (int n = 0; n < 12; n++) begin
      i_req = 1'b1; i_addr = $urandom;
      d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
      d_addr = $urandom; d_wdata = $urandom;
      run_txn(0, 0, $urandom, "starve");
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_spurious();
    for (int k = 0; k < 3; k++) begin
      m_rvalid = 1'b1; m_gnt = 1'($urandom_range(0, 1)); #1;
      n_cmp++;
      if ({m_req, i_gnt, d_gnt, i_rvalid, d_rvalid} !== 5'b0) begin
        n_err++;
        $display("FAIL spurious_idle: got %b want 00000", {m_req, i_gnt, d_gnt, i_rvalid, d_rvalid});
      end
      @(negedge clk);
    end
    m_rvalid = 1'b0;
    // run_txn drives random m_rvalid through REQ, covering spurious responses there
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h40; d_wdata = 32'h1234;
    run_txn(2, 0, 32'hCAFE_0001, "spurious_req");
  endtask

  task automatic test_reset_rsp();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h80; i_req = 1'b0;
    m_gnt = 1'b1;
    @(negedge clk);            // REQ, granted this cycle
    @(negedge clk);            // RSP
    d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, m_be, m_addr, m_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_in_rsp: got gnt=%b%b rv=%b%b req=%b addr=%h want all 0",
               i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_addr);
    end
    @(negedge clk);
    rst_n = 1'b1; starve = 0;
    for (int k = 0; k < 2; k++) begin
      m_rvalid = 1'b1; m_rdata = $urandom; #1;
      n_cmp++;
      if ({m_req, i_rvalid, d_rvalid} !== 3'b0) begin
        n_err++;
        $display("FAIL late_rvalid: got req=%b rv=%b%b want 000", m_req, i_rvalid, d_rvalid);
      end
      @(negedge clk);
    end
    m_rvalid = 1'b0;
    i_req = 1'b1; i_addr = 32'h300;
    run_txn(1, 1, 32'h0BAD_F00D, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      if (!i_req && $urandom_range(0, 1) == 1) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      if (i_req || d_req) begin
        run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom, "random");
      end else begin
        m_rvalid = 1'($urandom_range(0, 1)); m_gnt = 1'($urandom_range(0, 1)); #1;
        n_cmp++;
        if ({m_req, i_gnt, d_gnt, i_rvalid, d_rvalid} !== 5'b0) begin
          n_err++;
          $display("FAIL random_idle: got %b want 00000", {m_req, i_gnt, d_gnt, i_rvalid, d_rvalid});
        end
        @(negedge clk);
        m_rvalid = 1'b0; m_gnt = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_starve();
    test_spurious();
    test_reset_rsp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
